regfile_write_arbiter: RTL and testbench

//  Shares the write side of a bank of single_register instances among NREQ writers (ALU, load unit, CSR path).

---
 rtl/regwr_pkg.sv | 10 +
 rtl/rr_pick.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 86 ++++++++
 tb/tb_regfile_write_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regwr_pkg.sv
// Shared types and sizes for the register-file write arbiter and its round-robin picker.
package regwr_pkg;
    localparam int NREGS_DEF = 16;
    localparam int ADDR_BITS = $clog2(NREGS_DEF);
    localparam int MAX_NREQ  = 4;
    localparam int IDX_BITS  = $clog2(MAX_NREQ);

    typedef logic [ADDR_BITS-1:0] reg_addr_t;
    typedef logic [IDX_BITS-1:0]  req_idx_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping mod NREQ.
module rr_pick
    import regwr_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] valid,
    input  req_idx_t        ptr,
    output logic [NREQ-1:0] grant,
    output req_idx_t        winner,
    output logic            any
);
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!any && valid[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                winner      = req_idx_t'(idx);
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter driving a register bank with a registered one-hot strobe.
// Optional macro REGWR_ZERO_DROP_EN makes register 0 hardwired (writes to it are accepted but dropped).
module regfile_write_arbiter
    import regwr_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int NREGS     = 16,
    parameter int DATA_BITS = 32,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*DATA_BITS-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREGS-1:0]          reg_wenable,
    output logic [DATA_BITS-1:0]      reg_wdata,
    output logic                      pend_valid,
    output logic [AW-1:0]             pend_addr
);
    req_idx_t                ptr;
    req_idx_t                winner;
    logic                    xfer;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         valid_eff;
    logic [AW-1:0]           sel_addr;
    logic [DATA_BITS-1:0]    sel_data;

    function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] a);
        logic [NREGS-1:0] d;
        d    = '0;
        d[a] = 1'b1;
`ifdef REGWR_ZERO_DROP_EN
        if (a == '0)
            d = '0;
`endif
        return d;
    endfunction

    // Grants are suppressed during reset as well as freeze so nothing is accepted and lost.
    assign valid_eff = (freeze || rst) ? '0 : req_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid  (valid_eff),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .any    (xfer)
    );

    assign req_ready = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            reg_wenable <= '0;
            reg_wdata   <= '0;
            pend_addr   <= '0;
        end else if (xfer) begin
            if (int'(winner) == NREQ - 1)
                ptr <= '0;
            else
                ptr <= winner + 1'b1;
            reg_wenable <= decode(sel_addr);
            reg_wdata   <= sel_data;
            pend_addr   <= sel_addr;
        end else begin
            reg_wenable <= '0;
        end
    end

    assign pend_valid = |reg_wenable;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small behavioural register bank.
module tb_regfile_write_arbiter;
    localparam int NREQ = 2;
    localparam int NREGS = 16;
    localparam int DW = 32;
    localparam int AW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             freeze;
    logic [NREQ-1:0]  req_valid;
    logic [AW-1:0]    addr0, addr1;
    logic [DW-1:0]    data0, data1;
    logic [NREQ-1:0]  req_ready;
    logic [NREGS-1:0] reg_wenable;
    logic [DW-1:0]    reg_wdata;
    logic             pend_valid;
    logic [AW-1:0]    pend_addr;
    logic             bank_init;
    logic [DW-1:0]    bank [NREGS];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .DATA_BITS(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .req_valid   (req_valid),
        .req_addr    ({addr1, addr0}),
        .req_data    ({data1, data0}),
        .req_ready   (req_ready),
        .reg_wenable (reg_wenable),
        .reg_wdata   (reg_wdata),
        .pend_valid  (pend_valid),
        .pend_addr   (pend_addr)
    );

    always @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (bank_init)
                bank[i] <= '0;
            else if (reg_wenable[i])
                bank[i] <= reg_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; req_valid = 2'b11; bank_init = 1'b1;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        step();
        checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        checks++; if (reg_wenable !== 16'h0000) begin fails++; $display("FAIL reset_wenable: got %h expected 0000", reg_wenable); end
        checks++; if (pend_valid !== 1'b0) begin fails++; $display("FAIL reset_pend_valid: got %b expected 0", pend_valid); end
        checks++; if (reg_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h expected 0", reg_wdata); end
        freeze = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready_frozen: got %b expected 00", req_ready); end
        freeze = 1'b0;
        step();
        rst = 1'b0; bank_init = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL first_grant: got %b expected 01", req_ready); end
        req_valid = 2'b00; #1;
    endtask

    task automatic test_back_to_back();
        req_valid = 2'b11; addr0 = 4'd5; addr1 = 4'd6;
        data0 = 32'h1111_0005; data1 = 32'h2222_0006; #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            step();
            checks++;
            if (reg_wenable !== ((k % 2 == 0) ? 16'h0020 : 16'h0040)) begin
                fails++; $display("FAIL b2b_wenable[%0d]: got %h expected %h", k, reg_wenable, (k % 2 == 0) ? 16'h0020 : 16'h0040);
            end
            checks++;
            if (reg_wdata !== ((k % 2 == 0) ? 32'h1111_0005 : 32'h2222_0006)) begin
                fails++; $display("FAIL b2b_wdata[%0d]: got %h", k, reg_wdata);
            end
        end
        req_valid = 2'b00;
        step();
        checks++; if (reg_wenable !== 16'h0000) begin fails++; $display("FAIL b2b_idle: got %h expected 0000", reg_wenable); end
        checks++; if (bank[5] !== 32'h1111_0005) begin fails++; $display("FAIL b2b_bank5: got %h expected 11110005", bank[5]); end
        checks++; if (bank[6] !== 32'h2222_0006) begin fails++; $display("FAIL b2b_bank6: got %h expected 22220006", bank[6]); end
    endtask

    task automatic test_single();
        req_valid = 2'b01; addr0 = 4'd3; data0 = 32'hA5A5_0001; #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        step();
        req_valid = 2'b00;
        checks++; if (reg_wenable !== 16'h0008) begin fails++; $display("FAIL single_wenable: got %h expected 0008", reg_wenable); end
        checks++; if (reg_wdata !== 32'hA5A5_0001) begin fails++; $display("FAIL single_wdata: got %h expected a5a50001", reg_wdata); end
        checks++; if (pend_valid !== 1'b1 || pend_addr !== 4'd3) begin fails++; $display("FAIL single_pend: got %b/%0d expected 1/3", pend_valid, pend_addr); end
        step();
        checks++; if (bank[3] !== 32'hA5A5_0001) begin fails++; $display("FAIL single_bank3: got %h expected a5a50001", bank[3]); end
        checks++; if (reg_wenable !== 16'h0000 || pend_valid !== 1'b0) begin fails++; $display("FAIL single_drop: got %h/%b expected 0000/0", reg_wenable, pend_valid); end
    endtask

    task automatic test_zero_write();
        req_valid = 2'b10; addr1 = 4'd0; data1 = 32'hFFFF_FFFF; #1;
        checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL zero_ready: got %b expected 10", req_ready); end
        step();
        req_valid = 2'b00;
`ifdef REGWR_ZERO_DROP_EN
        checks++; if (reg_wenable !== 16'h0000 || pend_valid !== 1'b0) begin fails++; $display("FAIL zero_wenable: got %h/%b expected 0000/0", reg_wenable, pend_valid); end
`else
        checks++; if (reg_wenable !== 16'h0001 || pend_valid !== 1'b1) begin fails++; $display("FAIL zero_wenable: got %h/%b expected 0001/1", reg_wenable, pend_valid); end
`endif
        step();
`ifdef REGWR_ZERO_DROP_EN
        checks++; if (bank[0] !== 32'h0) begin fails++; $display("FAIL zero_bank0: got %h expected 0", bank[0]); end
`else
        checks++; if (bank[0] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL zero_bank0: got %h expected ffffffff", bank[0]); end
`endif
        req_valid = 2'b11; #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL zero_ptr_adv: got %b expected 01", req_ready); end
        req_valid = 2'b00; #1;
    endtask

    task automatic test_freeze();
        req_valid = 2'b11; addr0 = 4'd5; addr1 = 4'd6;
        data0 = 32'h5555_0005; data1 = 32'h6666_0006; #1;
        checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL freeze_pre_ready: got %b expected 01", req_ready); end
        step();
        freeze = 1'b1; #1;
        checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL freeze_ready: got %b expected 00", req_ready); end
        checks++; if (reg_wenable !== 16'h0020) begin fails++; $display("FAIL freeze_inflight: got %h expected 0020", reg_wenable); end
        step();
        checks++; if (reg_wenable !== 16'h0000 || pend_valid !== 1'b0) begin fails++; $display("FAIL freeze_nostrobe: got %h/%b expected 0000/0", reg_wenable, pend_valid); end
        step();
        checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL freeze_hold_ready: got %b expected 00", req_ready); end
        freeze = 1'b0; #1;
        checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL freeze_resume: got %b expected 10", req_ready); end
        req_valid = 2'b00; #1;
    endtask

    task automatic test_reset_mid_write();
        req_valid = 2'b01; addr0 = 4'd8; data0 = 32'h8888_0001; #1;
        step();
        req_valid = 2'b00;
        step();
        checks++; if (bank[8] !== 32'h8888_0001) begin fails++; $display("FAIL rmw_preload: got %h expected 88880001", bank[8]); end
        req_valid = 2'b01; data0 = 32'hDEAD_BEEF; #1;
        step();
        req_valid = 2'b00;
        checks++; if (reg_wenable !== 16'h0100) begin fails++; $display("FAIL rmw_strobe: got %h expected 0100", reg_wenable); end
        #2 rst = 1'b1; #1;
        checks++; if (reg_wenable !== 16'h0000 || pend_valid !== 1'b0) begin fails++; $display("FAIL rmw_async_drop: got %h/%b expected 0000/0", reg_wenable, pend_valid); end
        step();
        checks++; if (bank[8] !== 32'h8888_0001) begin fails++; $display("FAIL rmw_bank8: got %h expected 88880001", bank[8]); end
        rst = 1'b0; #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_zero_write();
        test_freeze();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
